mem_rx: RTL
===========

MEM_RX -- requirements
Module: mem_rx

Interface
REQ-001 Parameter TIMEOUT, default 15: max cycles spent waiting for read data before a bus error.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ren_i  input  1  load pending from the memory-execute stage (registered there).
REQ-005 scope_i  input  2  load size: 2'b11 word, 2'b01 half, 2'b00 byte; 2'b10 reserved.
REQ-006 signed_i  input  1  1 = sign-extend, 0 = zero-extend.
REQ-007 addr_lsb2_i  input  2  address bits [1:0] of the load.
REQ-008 wreg_i  input  5  destination register index.
REQ-009 mem_rdata_i  input  32  word-aligned read data from mem-cache.
REQ-010 mem_rvalid_i  input  1  mem_rdata_i valid this cycle.
REQ-011 wb_en_o  output  1  one-cycle writeback strobe.
REQ-012 wb_reg_o  output  5  writeback register index.
REQ-013 wb_data_o  output  32  extracted, extended load data.
REQ-014 stall_o  output  1  pipeline hold while waiting for data.
REQ-015 err_o  output  1  one-cycle load error strobe.
REQ-016 err_code_o  output  2  2'b01 timeout, 2'b10 misaligned, 2'b11 reserved scope, 2'b00 none.

Function
REQ-017 FSM states SHALL be IDLE and WAIT; stall_o SHALL equal (state==WAIT), combinational from state only.
REQ-018 In IDLE with ren_i=1 the block SHALL capture scope_i, signed_i, addr_lsb2_i, wreg_i.
REQ-019 IDLE, ren_i=1, mem_rvalid_i=1: wb_en_o=1 with data on the next edge; state stays IDLE (back-to-back loads at 1/cycle).
REQ-020 IDLE, ren_i=1, mem_rvalid_i=0: go to WAIT, wait counter cleared to 0.
REQ-021 WAIT, mem_rvalid_i=1: extract from current mem_rdata_i using captured fields, wb_en_o=1 next edge, return to IDLE.
REQ-022 WAIT, mem_rvalid_i=0: counter increments; when counter reaches TIMEOUT-1 -> err_o=1, err_code_o=2'b01 next edge, no writeback, return to IDLE.
REQ-023 ren_i SHALL be ignored in WAIT; mem_rvalid_i SHALL be ignored in IDLE when ren_i=0.
REQ-024 Byte: lane = rdata[8*lsb+7 : 8*lsb] (little-endian); half: lsb[1]=0 -> [15:0], 1 -> [31:16]; word: [31:0].
REQ-025 Byte/half SHALL be sign-extended from bit 7/15 when signed, else zero-extended to 32 bits.
REQ-026 scope 2'b10: no writeback, err_o=1, err_code_o=2'b11, one cycle after data arrives.
REQ-027 wb_en_o and err_o SHALL never both be 1; both SHALL be 0 in every cycle without an event; wb_data_o/wb_reg_o hold last value otherwise.
REQ-028 err_code_o SHALL be 2'b00 whenever err_o=0.

Reset
REQ-029 Asserting rst_n low SHALL immediately force IDLE, counter 0, wb_en_o=0, wb_reg_o=0, wb_data_o=0, err_o=0, err_code_o=0, stall_o=0.
REQ-030 Reset during WAIT SHALL abandon the load with no writeback and no error after release.

Configuration
REQ-031 Macro MEM_RX_ALIGN_CHECK_EN defined: half with lsb[0]=1 or word with lsb!=0 -> err_o=1, err_code_o=2'b10 on the edge after data would be taken, no writeback.
REQ-032 Macro undefined: no alignment check; misaligned half uses lsb[1] only, misaligned word returns full rdata; code 2'b10 never produced.

Structure
REQ-033 Shared package/header: scope encodings (word/half/byte), err_code encodings, FSM state encodings.
REQ-034 One sub-module mem_rx_extract: combinational lane select + sign/zero extension (rdata, scope, signed, lsb -> 32-bit data).

Verification
REQ-035 rdata=32'h8899AABB, byte, signed, lsb=2, rvalid same cycle -> next cycle wb_en_o=1, wb_data_o=32'hFFFFFF99, stall_o never 1.
REQ-036 rdata=32'h8899AABB, half, unsigned, lsb=2, rvalid after 3 cycles -> stall_o=1 for 3 cycles, then wb_data_o=32'h00008899.
REQ-037 Load, rvalid never, TIMEOUT=15 -> stall_o high 15 cycles, err_o=1, err_code_o=2'b01, no wb_en_o.
REQ-038 With MEM_RX_ALIGN_CHECK_EN: word load lsb=1 -> err_code_o=2'b10, no writeback; without macro -> wb_data_o=rdata.
REQ-039 Four back-to-back loads with rvalid each cycle, wreg 1..4 -> four consecutive wb_en_o pulses, correct wb_reg_o order.
REQ-040 rst_n low in 2nd WAIT cycle, release, then rvalid=1 -> no wb_en_o, no err_o, outputs all zero.

Source files
------------

// File: rtl/mem_rx_pkg.sv
// mem_rx_pkg
//   Shared encodings for the load-receive block: load scope (size) codes,
//   error codes reported on err_code_o, FSM state type, and a helper that
//   decides whether a load address is misaligned for its size.
package mem_rx_pkg;

  // Load size encodings as presented on scope_i.
  localparam logic [1:0] SCOPE_BYTE = 2'b00;
  localparam logic [1:0] SCOPE_HALF = 2'b01;
  localparam logic [1:0] SCOPE_RSVD = 2'b10;
  localparam logic [1:0] SCOPE_WORD = 2'b11;

  // Error codes on err_code_o.
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_MISALIGN = 2'b10;
  localparam logic [1:0] ERR_SCOPE    = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Half loads need an even address, word loads need a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [1:0] scope, input logic [1:0] lsb);
    return ((scope == SCOPE_HALF) && lsb[0]) ||
           ((scope == SCOPE_WORD) && (lsb != 2'b00));
  endfunction

endpackage

// File: rtl/mem_rx_extract.sv
// mem_rx_extract
//   Combinational lane select and sign/zero extension of a word-aligned
//   read word into the 32-bit value written back for a load.
// Ports:
//   rdata_i  [31:0] word-aligned read data
//   scope_i  [1:0]  load size (byte/half/word)
//   signed_i        1 = sign-extend byte/half, 0 = zero-extend
//   lsb_i    [1:0]  address bits [1:0]
//   data_o   [31:0] extracted, extended data
module mem_rx_extract
  import mem_rx_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  scope_i,
  input  logic        signed_i,
  input  logic [1:0]  lsb_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    // Little-endian byte lanes.
    case (lsb_i)
      2'b00:   byte_lane = rdata_i[7:0];
      2'b01:   byte_lane = rdata_i[15:8];
      2'b10:   byte_lane = rdata_i[23:16];
      default: byte_lane = rdata_i[31:24];
    endcase

    // Only lsb[1] picks the half; an odd half address is not corrected here.
    half_lane = lsb_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (scope_i)
      SCOPE_BYTE: data_o = {{24{signed_i & byte_lane[7]}}, byte_lane};
      SCOPE_HALF: data_o = {{16{signed_i & half_lane[15]}}, half_lane};
      default:    data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_rx.sv
// mem_rx
//   Load-receive stage: accepts a pending load from the memory-execute
//   stage, waits for read data from the mem-cache (stalling the pipeline),
//   extracts and extends the addressed lane and issues a one-cycle
//   writeback, or a one-cycle error strobe on timeout / reserved size /
//   (optionally) misalignment.
// Configuration:
//   MEM_RX_ALIGN_CHECK_EN  when defined, misaligned half/word loads report
//                          ERR_MISALIGN instead of writing back.
// Parameters:
//   TIMEOUT  max cycles spent in WAIT before a timeout error (>= 1)
// Ports:
//   clk, rst_n (async, active-low)
//   ren_i, scope_i[1:0], signed_i, addr_lsb2_i[1:0], wreg_i[4:0]  load request
//   mem_rdata_i[31:0], mem_rvalid_i                               read data
//   wb_en_o, wb_reg_o[4:0], wb_data_o[31:0]                       writeback
//   stall_o                                                       pipeline hold
//   err_o, err_code_o[1:0]                                        error strobe
module mem_rx
  import mem_rx_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ren_i,
  input  logic [1:0]  scope_i,
  input  logic        signed_i,
  input  logic [1:0]  addr_lsb2_i,
  input  logic [4:0]  wreg_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_rvalid_i,
  output logic        wb_en_o,
  output logic [4:0]  wb_reg_o,
  output logic [31:0] wb_data_o,
  output logic        stall_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;

  // Load attributes captured when the load is accepted in IDLE.
  logic [1:0] scope_q;
  logic       signed_q;
  logic [1:0] lsb_q;
  logic [4:0] wreg_q;

  logic        wb_en_q;
  logic [4:0]  wb_reg_q;
  logic [31:0] wb_data_q;
  logic        err_q;
  logic [1:0]  err_code_q;

  // When data arrives in the same cycle as the request, the captured
  // registers are not loaded yet, so use the live inputs instead.
  logic        in_idle;
  logic [1:0]  sel_scope;
  logic        sel_signed;
  logic [1:0]  sel_lsb;
  logic [4:0]  sel_wreg;
  logic        data_take;
  logic        misalign;
  logic [31:0] ext_data;

  assign in_idle    = (state_q == ST_IDLE);
  assign sel_scope  = in_idle ? scope_i     : scope_q;
  assign sel_signed = in_idle ? signed_i    : signed_q;
  assign sel_lsb    = in_idle ? addr_lsb2_i : lsb_q;
  assign sel_wreg   = in_idle ? wreg_i      : wreg_q;

  // rvalid only counts when a load is actually outstanding.
  assign data_take = mem_rvalid_i && (in_idle ? ren_i : 1'b1);

`ifdef MEM_RX_ALIGN_CHECK_EN
  assign misalign = is_misaligned(sel_scope, sel_lsb);
`else
  assign misalign = 1'b0;
`endif

  mem_rx_extract u_extract (
    .rdata_i  (mem_rdata_i),
    .scope_i  (sel_scope),
    .signed_i (sel_signed),
    .lsb_i    (sel_lsb),
    .data_o   (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      scope_q    <= SCOPE_BYTE;
      signed_q   <= 1'b0;
      lsb_q      <= 2'b00;
      wreg_q     <= 5'd0;
      wb_en_q    <= 1'b0;
      wb_reg_q   <= 5'd0;
      wb_data_q  <= 32'd0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      // Strobes default low; wb_reg/wb_data hold their last value.
      wb_en_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;

      if (data_take) begin
        if (sel_scope == SCOPE_RSVD) begin
          err_q      <= 1'b1;
          err_code_q <= ERR_SCOPE;
        end else if (misalign) begin
          err_q      <= 1'b1;
          err_code_q <= ERR_MISALIGN;
        end else begin
          wb_en_q   <= 1'b1;
          wb_reg_q  <= sel_wreg;
          wb_data_q <= ext_data;
        end
      end

      if (state_q == ST_IDLE) begin
        if (ren_i) begin
          scope_q  <= scope_i;
          signed_q <= signed_i;
          lsb_q    <= addr_lsb2_i;
          wreg_q   <= wreg_i;
          if (!mem_rvalid_i) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
          end
        end
      end else begin
        if (mem_rvalid_i) begin
          state_q <= ST_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_q    <= ST_IDLE;
          err_q      <= 1'b1;
          err_code_q <= ERR_TIMEOUT;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign wb_en_o    = wb_en_q;
  assign wb_reg_o   = wb_reg_q;
  assign wb_data_o  = wb_data_q;
  assign err_o      = err_q;
  assign err_code_o = err_code_q;
  assign stall_o    = (state_q == ST_WAIT);

endmodule
